// File: rtl/i3c_cmd_scheduler.sv
// i3c_cmd_scheduler
//
// Fetches one 5-byte command descriptor from the register file on a host
// start pulse, decodes it, then sequences the engines in order:
// ENTHDR broadcast (SDR engine) -> transaction (SDR / HDR-DDR / CCC) ->
// optional HDR exit pattern + STOP.
//
// Ports
//   i_sdr_clk, i_sdr_rst_n         clock, asynchronous active-low reset
//   i_start, i_base_addr           start pulse and descriptor base address
//   o_regf_rd_en, o_regf_addr,
//   i_regf_data                    register-file read port (1-cycle latency)
//   o_sdr_enable / i_sdr_done      SDR engine handshake
//   o_ddr_enable / i_ddr_done      HDR-DDR engine handshake
//   o_ccc_enable / i_ccc_done      CCC block handshake
//   o_exit_req   / i_exit_done     HDR exit pattern + STOP handshake
//   o_tid .. o_def_byte            decoded descriptor fields
//   o_hdr_active                   bus currently in HDR mode
//   o_busy, o_cmd_done, o_error,
//   o_err_code                     status (01 attr, 10 timeout, 11 mode)

module i3c_cmd_scheduler #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        i_sdr_clk,
  input  logic        i_sdr_rst_n,
  input  logic        i_start,
  input  logic [11:0] i_base_addr,
  output logic        o_regf_rd_en,
  output logic [11:0] o_regf_addr,
  input  logic [7:0]  i_regf_data,
  output logic        o_sdr_enable,
  input  logic        i_sdr_done,
  output logic        o_ddr_enable,
  input  logic        i_ddr_done,
  output logic        o_ccc_enable,
  input  logic        i_ccc_done,
  output logic        o_exit_req,
  input  logic        i_exit_done,
  output logic [3:0]  o_tid,
  output logic [7:0]  o_cmd,
  output logic        o_cp,
  output logic [4:0]  o_dev_index,
  output logic [2:0]  o_dtt,
  output logic [2:0]  o_mode,
  output logic        o_toc,
  output logic        o_wroc,
  output logic        o_rnw,
  output logic [7:0]  o_def_byte,
  output logic        o_hdr_active,
  output logic        o_busy,
  output logic        o_cmd_done,
  output logic        o_error,
  output logic [1:0]  o_err_code
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, ENTHDR, XFER, EXIT, DONE, ERROR
  } state_t;

  typedef struct packed {
    logic [2:0] attr;
    logic [3:0] tid;
    logic [7:0] cmd;
    logic       cp;
    logic [4:0] dev_index;
    logic [2:0] dtt;
    logic [2:0] mode;
    logic       toc;
    logic       wroc;
    logic       rnw;
    logic [7:0] def_byte;
  } desc_t;

  // Last counter value before the wait is declared timed out; a wait state
  // therefore lasts at most TIMEOUT_CYCLES cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  MODE_SDR = 3'd0;
  localparam logic [2:0]  MODE_DDR = 3'd6;

  state_t      state_reg, state_next;
  desc_t       desc_reg, desc_next;
  logic [2:0]  idx_reg, idx_next;
  logic        rd_en_reg, rd_en_next;
  logic [11:0] addr_reg, addr_next;
  logic [15:0] tmo_reg, tmo_next;
  logic [1:0]  err_code_reg, err_code_next;
  logic        hdr_reg, hdr_next;
  logic        sdr_en_reg, sdr_en_next;
  logic        ddr_en_reg, ddr_en_next;
  logic        ccc_en_reg, ccc_en_next;
  logic        exit_reg, exit_next;
  logic        cmd_done_reg, cmd_done_next;
  logic        error_reg, error_next;
  logic        wait_done;

  // Done input that matters in the current wait state; all others are ignored.
  always_comb begin
    wait_done = 1'b0;
    case (state_reg)
      ENTHDR: wait_done = i_sdr_done;
      XFER: begin
        if (desc_reg.cp)                    wait_done = i_ccc_done;
        else if (desc_reg.mode == MODE_DDR) wait_done = i_ddr_done;
        else                                wait_done = i_sdr_done;
      end
      EXIT:    wait_done = i_exit_done;
      default: wait_done = 1'b0;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    desc_next     = desc_reg;
    idx_next      = idx_reg;
    rd_en_next    = 1'b0;
    addr_next     = addr_reg;
    tmo_next      = '0;
    err_code_next = err_code_reg;
    hdr_next      = hdr_reg;

    case (state_reg)
      IDLE: begin
        if (i_start) begin
          state_next    = FETCH;
          rd_en_next    = 1'b1;
          addr_next     = i_base_addr;
          idx_next      = 3'd0;
          err_code_next = 2'b00;
        end
      end

      // idx_reg counts FETCH cycles 0..5: strobes go out in cycles 0..4,
      // byte k arrives in cycle k+1.
      FETCH: begin
        idx_next = idx_reg + 3'd1;
        if (idx_reg < 3'd4) begin
          rd_en_next = 1'b1;
          addr_next  = addr_reg + 12'd1;
        end
        case (idx_reg)
          3'd1: {desc_next.cmd[0], desc_next.tid, desc_next.attr} = i_regf_data;
          3'd2: {desc_next.cp, desc_next.cmd[7:1]} = i_regf_data;
          3'd3: begin
            desc_next.dtt[0]    = i_regf_data[7];
            desc_next.dev_index = i_regf_data[4:0];
          end
          3'd4: {desc_next.toc, desc_next.wroc, desc_next.rnw,
                 desc_next.mode, desc_next.dtt[2:1]} = i_regf_data;
          3'd5: desc_next.def_byte = i_regf_data;
          default: ;
        endcase
        if (idx_reg == 3'd5) state_next = DECODE;
      end

      DECODE: begin
        if (desc_reg.attr != 3'b000) begin
          state_next    = ERROR;
          err_code_next = 2'b01;
        end else if (desc_reg.mode == MODE_DDR) begin
          // Already in HDR: no repeated ENTHDR broadcast.
          state_next = hdr_reg ? XFER : ENTHDR;
        end else if (desc_reg.mode == MODE_SDR && !hdr_reg) begin
          state_next = XFER;
        end else begin
          state_next    = ERROR;
          err_code_next = 2'b11;
        end
      end

      // A done in the same cycle as the timeout takes precedence.
      ENTHDR, XFER, EXIT: begin
        if (wait_done) begin
          case (state_reg)
            ENTHDR: begin
              state_next = XFER;
              hdr_next   = 1'b1;
            end
            XFER: state_next = (desc_reg.mode == MODE_DDR && desc_reg.toc) ? EXIT : DONE;
            default: begin
              state_next = DONE;
              hdr_next   = 1'b0;
            end
          endcase
        end else if (tmo_reg == TMO_LAST) begin
          state_next    = ERROR;
          err_code_next = 2'b10;
        end else begin
          tmo_next = tmo_reg + 16'd1;
        end
      end

      DONE:    state_next = IDLE;
      ERROR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (state_next == ERROR) hdr_next = 1'b0;

    // Registered handshakes derived from the state being entered, so an
    // enable drops and its successor rises in the same cycle.
    sdr_en_next   = (state_next == ENTHDR) ||
                    (state_next == XFER && !desc_reg.cp && desc_reg.mode == MODE_SDR);
    ddr_en_next   = (state_next == XFER && !desc_reg.cp && desc_reg.mode == MODE_DDR);
    ccc_en_next   = (state_next == XFER && desc_reg.cp);
    exit_next     = (state_next == EXIT);
    cmd_done_next = (state_next == DONE);
    error_next    = (state_next == ERROR);
  end

  always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
    if (!i_sdr_rst_n) begin
      state_reg    <= IDLE;
      desc_reg     <= '0;
      idx_reg      <= '0;
      rd_en_reg    <= 1'b0;
      addr_reg     <= '0;
      tmo_reg      <= '0;
      err_code_reg <= '0;
      hdr_reg      <= 1'b0;
      sdr_en_reg   <= 1'b0;
      ddr_en_reg   <= 1'b0;
      ccc_en_reg   <= 1'b0;
      exit_reg     <= 1'b0;
      cmd_done_reg <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      desc_reg     <= desc_next;
      idx_reg      <= idx_next;
      rd_en_reg    <= rd_en_next;
      addr_reg     <= addr_next;
      tmo_reg      <= tmo_next;
      err_code_reg <= err_code_next;
      hdr_reg      <= hdr_next;
      sdr_en_reg   <= sdr_en_next;
      ddr_en_reg   <= ddr_en_next;
      ccc_en_reg   <= ccc_en_next;
      exit_reg     <= exit_next;
      cmd_done_reg <= cmd_done_next;
      error_reg    <= error_next;
    end
  end

  assign o_regf_rd_en = rd_en_reg;
  assign o_regf_addr  = addr_reg;
  assign o_sdr_enable = sdr_en_reg;
  assign o_ddr_enable = ddr_en_reg;
  assign o_ccc_enable = ccc_en_reg;
  assign o_exit_req   = exit_reg;
  assign o_tid        = desc_reg.tid;
  assign o_cmd        = desc_reg.cmd;
  assign o_cp         = desc_reg.cp;
  assign o_dev_index  = desc_reg.dev_index;
  assign o_dtt        = desc_reg.dtt;
  assign o_mode       = desc_reg.mode;
  assign o_toc        = desc_reg.toc;
  assign o_wroc       = desc_reg.wroc;
  assign o_rnw        = desc_reg.rnw;
  assign o_def_byte   = desc_reg.def_byte;
  assign o_hdr_active = hdr_reg;
  assign o_busy       = (state_reg != IDLE);
  assign o_cmd_done   = cmd_done_reg;
  assign o_error      = error_reg;
  assign o_err_code   = err_code_reg;

endmodule

// File: tb/tb_i3c_cmd_scheduler.sv
// Directed testbench for i3c_cmd_scheduler (TIMEOUT_CYCLES = 20).
// Outputs are sampled on the falling clock edge; inputs change there too.

module tb_i3c_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [11:0] i_base_addr;
  logic        o_regf_rd_en;
  logic [11:0] o_regf_addr;
  logic [7:0]  i_regf_data;
  logic        o_sdr_enable, i_sdr_done;
  logic        o_ddr_enable, i_ddr_done;
  logic        o_ccc_enable, i_ccc_done;
  logic        o_exit_req, i_exit_done;
  logic [3:0]  o_tid;
  logic [7:0]  o_cmd;
  logic        o_cp;
  logic [4:0]  o_dev_index;
  logic [2:0]  o_dtt;
  logic [2:0]  o_mode;
  logic        o_toc, o_wroc, o_rnw;
  logic [7:0]  o_def_byte;
  logic        o_hdr_active, o_busy, o_cmd_done, o_error;
  logic [1:0]  o_err_code;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem [4096];
  logic        pend_v = 1'b0;
  logic [11:0] pend_a = '0;
  logic        en_seen = 1'b0;

  always #5 clk = ~clk;

  i3c_cmd_scheduler #(.TIMEOUT_CYCLES(20)) dut (
    .i_sdr_clk   (clk),
    .i_sdr_rst_n (rst_n),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .o_regf_rd_en(o_regf_rd_en),
    .o_regf_addr (o_regf_addr),
    .i_regf_data (i_regf_data),
    .o_sdr_enable(o_sdr_enable),
    .i_sdr_done  (i_sdr_done),
    .o_ddr_enable(o_ddr_enable),
    .i_ddr_done  (i_ddr_done),
    .o_ccc_enable(o_ccc_enable),
    .i_ccc_done  (i_ccc_done),
    .o_exit_req  (o_exit_req),
    .i_exit_done (i_exit_done),
    .o_tid       (o_tid),
    .o_cmd       (o_cmd),
    .o_cp        (o_cp),
    .o_dev_index (o_dev_index),
    .o_dtt       (o_dtt),
    .o_mode      (o_mode),
    .o_toc       (o_toc),
    .o_wroc      (o_wroc),
    .o_rnw       (o_rnw),
    .o_def_byte  (o_def_byte),
    .o_hdr_active(o_hdr_active),
    .o_busy      (o_busy),
    .o_cmd_done  (o_cmd_done),
    .o_error     (o_error),
    .o_err_code  (o_err_code)
  );

  // Register-file model: data for a strobe seen in one cycle is presented in
  // the next cycle only; otherwise a filler value is driven.
  always @(negedge clk) begin
    i_regf_data = pend_v ? mem[pend_a] : 8'hEE;
    pend_v      = o_regf_rd_en;
    pend_a      = o_regf_addr;
  end

  always @(negedge clk) begin
    if (o_sdr_enable || o_ddr_enable || o_ccc_enable || o_exit_req) en_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ens();
    return {o_sdr_enable, o_ddr_enable, o_ccc_enable, o_exit_req};
  endfunction

  function automatic logic [63:0] all_outs();
    return {6'd0, o_regf_rd_en, o_regf_addr, ens(), o_tid, o_cmd, o_cp, o_dev_index,
            o_dtt, o_mode, o_toc, o_wroc, o_rnw, o_def_byte,
            o_hdr_active, o_busy, o_cmd_done, o_error, o_err_code};
  endfunction

  task automatic load(input logic [11:0] base, input logic [39:0] bytes);
    for (int k = 0; k < 5; k++) mem[base + 12'(k)] = bytes[8*(4-k) +: 8];
  endtask

  // Called at a falling edge whose following rising edge is in IDLE.
  // Returns at the falling edge of the DECODE cycle (cycle 7).
  task automatic fetch(input logic [11:0] base);
    logic [11:0] a;
    i_base_addr = base;
    i_start     = 1'b1;
    @(negedge clk);
    i_start     = 1'b0;
    i_base_addr = ~base;
    check("start_errcode_clear", 64'(o_err_code), 64'd0);
    check("start_busy", 64'(o_busy), 64'd1);
    for (int k = 0; k < 5; k++) begin
      a = base + 12'(k);
      check("fetch_rd_en", 64'(o_regf_rd_en), 64'd1);
      check("fetch_addr", 64'(o_regf_addr), 64'(a));
      @(negedge clk);
    end
    check("fetch_rd_en_low", 64'(o_regf_rd_en), 64'd0);
    @(negedge clk);
    check("decode_no_enable", 64'(ens()), 64'd0);
  endtask

  // One-cycle done pulse; returns at the next falling edge.
  task automatic give(input int which);
    case (which)
      0: i_sdr_done  = 1'b1;
      1: i_ddr_done  = 1'b1;
      2: i_ccc_done  = 1'b1;
      default: i_exit_done = 1'b1;
    endcase
    @(negedge clk);
    i_sdr_done  = 1'b0;
    i_ddr_done  = 1'b0;
    i_ccc_done  = 1'b0;
    i_exit_done = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic hdr);
    check({tag, "_cmd_done"}, 64'(o_cmd_done), 64'd1);
    check({tag, "_en_idle"}, 64'(ens()), 64'd0);
    check({tag, "_hdr"}, 64'(o_hdr_active), 64'(hdr));
    check({tag, "_busy_last"}, 64'(o_busy), 64'd1);
    @(negedge clk);
    check({tag, "_pulse_end"}, 64'({o_cmd_done, o_busy}), 64'd0);
    $display("txn %s complete", tag);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_regf_data = '0;
    i_sdr_done = 1'b0; i_ddr_done = 1'b0; i_ccc_done = 1'b0; i_exit_done = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    load(12'd1000, 40'h00_00_00_98_00);
    load(12'd16,   40'h00_00_00_18_00);
    load(12'd32,   40'h00_80_00_98_00);
    load(12'd48,   40'hD0_2D_F3_62_A5);
    load(12'd64,   40'h01_00_00_00_00);
    load(12'd80,   40'h00_00_00_0C_00);
    load(12'd96,   40'h00_00_00_18_00);
    load(12'd4094, 40'h00_00_00_98_00);

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // HDR write with exit
    fetch(12'd1000);
    @(negedge clk);
    check("t1_enthdr", 64'(ens()), 64'b1000);
    check("t1_hdr_before", 64'(o_hdr_active), 64'd0);
    check("t1_mode_toc", 64'({o_mode, o_toc}), 64'b110_1);
    repeat (2) @(negedge clk);
    check("t1_enthdr_hold", 64'(ens()), 64'b1000);
    give(0);
    check("t1_ddr", 64'(ens()), 64'b0100);
    check("t1_hdr_on", 64'(o_hdr_active), 64'd1);
    give(1);
    check("t1_exit", 64'(ens()), 64'b0001);
    give(3);
    expect_done("t1", 1'b0);

    // HDR without exit, then HDR CCC reusing the open HDR session
    fetch(12'd16);
    @(negedge clk);
    check("t2a_enthdr", 64'(ens()), 64'b1000);
    give(0);
    check("t2a_ddr", 64'(ens()), 64'b0100);
    give(1);
    expect_done("t2a", 1'b1);
    fetch(12'd32);
    @(negedge clk);
    check("t2b_ccc_first", 64'(ens()), 64'b0010);
    check("t2b_cp", 64'(o_cp), 64'd1);
    give(1);
    check("t2b_ignore_ddr", 64'(ens()), 64'b0010);
    give(0);
    check("t2b_ignore_sdr", 64'(ens()), 64'b0010);
    give(2);
    check("t2b_exit", 64'(ens()), 64'b0001);
    give(3);
    expect_done("t2b", 1'b0);

    // SDR private transfer, full field decode (reserved bits set)
    fetch(12'd48);
    @(negedge clk);
    check("t3_sdr", 64'(ens()), 64'b1000);
    check("t3_tid", 64'(o_tid), 64'hA);
    check("t3_cmd", 64'(o_cmd), 64'h5B);
    check("t3_dev_dtt", 64'({o_dev_index, o_dtt}), 64'({5'h13, 3'd5}));
    check("t3_flags", 64'({o_cp, o_mode, o_toc, o_wroc, o_rnw}), 64'b0_000_0_1_1);
    check("t3_def", 64'(o_def_byte), 64'hA5);
    give(0);
    expect_done("t3", 1'b0);

    // Bad CMD_ATTR
    en_seen = 1'b0;
    fetch(12'd64);
    @(negedge clk);
    check("t4a_error", 64'({o_error, o_err_code, o_busy}), 64'b1_01_1);
    check("t4a_no_enable", 64'(ens()), 64'd0);
    @(negedge clk);
    check("t4a_after", 64'({o_error, o_err_code, o_busy}), 64'b0_01_0);
    check("t4a_never_enabled", 64'(en_seen), 64'd0);
    $display("txn t4a attr error");

    // Illegal MODE = 3
    fetch(12'd80);
    @(negedge clk);
    check("t4b_error", 64'({o_error, o_err_code}), 64'b1_11);
    @(negedge clk);
    $display("txn t4b mode error");

    // Timeout waiting for i_ddr_done
    fetch(12'd96);
    @(negedge clk);
    give(0);
    check("t5_ddr", 64'(ens()), 64'b0100);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!o_ddr_enable) break;
      n++;
    end
    check("t5_ddr_cycles", 64'(n), 64'd20);
    check("t5_error", 64'({o_error, o_err_code, o_hdr_active}), 64'b1_10_0);
    @(negedge clk);
    $display("txn t5 timeout");

    // Done in the very last cycle before timeout wins
    fetch(12'd96);
    @(negedge clk);
    give(0);
    repeat (19) @(negedge clk);
    check("t5b_ddr_last", 64'(ens()), 64'b0100);
    give(1);
    check("t5b_no_error", 64'({o_error, o_err_code}), 64'd0);
    expect_done("t5b", 1'b1);

    // Address wrap; HDR already active so no ENTHDR
    fetch(12'd4094);
    @(negedge clk);
    check("t6_ddr_direct", 64'(ens()), 64'b0100);
    give(1);
    check("t6_exit", 64'(ens()), 64'b0001);
    give(3);
    expect_done("t6", 1'b0);

    // Reset during HDR-DDR transfer, then a fresh command
    fetch(12'd1000);
    @(negedge clk);
    give(0);
    check("t7_ddr", 64'(ens()), 64'b0100);
    rst_n = 1'b0;
    #1;
    check("t7_reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch(12'd1000);
    @(negedge clk);
    check("t7_enthdr_again", 64'(ens()), 64'b1000);
    give(0);
    give(1);
    give(3);
    expect_done("t7", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
